// File: rtl/JZJCoreFTypes.sv
// JZJCoreFTypes: shared types for the port-mapped UART transmitter.
package JZJCoreFTypes;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} UartTxState_t;
  localparam int STATUS_ACK = 0;
  localparam int STATUS_FULL = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_BUSY = 3;
  localparam int STATUS_COUNT_LSB = 4;
endpackage

// File: rtl/port_uart_tx_fifo.sv
// port_uart_tx_fifo: byte FIFO between the CPU handshake and the UART shifter.
module port_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            dataIn,
  output logic [7:0]            dataOut,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam logic [DEPTH_LOG2:0] CAPACITY = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  logic [7:0] mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CAPACITY;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dataOut = mem[rd_ptr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (do_push && !do_pop) ? count + 1'b1 : (!do_push && do_pop) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= dataIn;
  end
endmodule

// File: rtl/port_uart_transmitter.sv
// port_uart_transmitter: CPU port responder that queues bytes from a toggle
// handshake and sends them as UART 8N1 on txd.
module port_uart_transmitter
  import JZJCoreFTypes::*;
#(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] portOutputWord,
  output logic [31:0] portInputWord,
  output logic        txd
);
  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLOCKS_PER_BIT - 1);
  UartTxState_t state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0] bit_idx, bit_next;
  logic [7:0] shift, shift_next, fifo_data;
  logic ack, push, pop, full, empty, txd_next, baud_zero;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic [31:0] status_next;
  logic unused_bits;
  assign unused_bits = ^portOutputWord[31:9];
  assign push = (portOutputWord[8] != ack) && !full;
  assign baud_zero = baud == '0;
  port_uart_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .dataIn(portOutputWord[7:0]),
    .dataOut(fifo_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    state_next = state;
    baud_next = (state == IDLE) ? baud : baud_zero ? BAUD_MAX : baud - 1'b1;
    bit_next = bit_idx;
    shift_next = shift;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_next = fifo_data;
        baud_next = BAUD_MAX;
        state_next = START;
      end
      START: if (baud_zero) begin
        bit_next = 3'd0;
        state_next = DATA;
      end
      DATA: if (baud_zero) begin
        shift_next = {1'b0, shift[7:1]};
        bit_next = (bit_idx == 3'd7) ? bit_idx : bit_idx + 3'd1;
        state_next = (bit_idx == 3'd7) ? STOP : DATA;
      end
      default: state_next = baud_zero ? IDLE : STOP;
    endcase
    // txd is registered from the next state so it switches with the state, never between.
    txd_next = (state_next == START) ? 1'b0 : (state_next == DATA) ? shift_next[0] : 1'b1;
  end
  always_comb begin
    status_next = '0;
    status_next[STATUS_ACK] = ack;
    status_next[STATUS_FULL] = full;
    status_next[STATUS_EMPTY] = empty;
    status_next[STATUS_BUSY] = state != IDLE;
    status_next[STATUS_COUNT_LSB +: 4] = 4'(count);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      txd <= 1'b1;
      ack <= 1'b0;
      portInputWord <= 32'h0000_0004;
    end else begin
      state <= state_next;
      baud <= baud_next;
      bit_idx <= bit_next;
      shift <= shift_next;
      txd <= txd_next;
      ack <= push ? portOutputWord[8] : ack;
      portInputWord <= status_next;
    end
  end
endmodule

// File: doc/port_uart_transmitter.md
Name: port_uart_transmitter

Overview:
- Device-side responder for one CPU memory-mapped port pair: consumes the word the CPU stores to a port output and produces the status word the CPU loads from the matching port input.
- Accepts bytes through a toggle handshake, buffers them in a small FIFO, and serialises them as UART 8N1 on txd.
- Sits outside the core, next to the memory controller, wired to e.g. portAOutput/portAInput.

Parameters:
- CLOCKS_PER_BIT, 434, clock cycles per UART bit (>=2).
- FIFO_DEPTH_LOG2, 2, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (1..3).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- portOutputWord  input  32  CPU-written command word: [7:0] data byte, [8] request toggle, [31:9] ignored.
- portInputWord  output  32  status word for CPU loads; registered.
- txd  output  1  UART serial out, idle high; registered.

Behaviour:
- Status word: [0] ackToggle, [1] fifoFull, [2] fifoEmpty, [3] busy (state != IDLE), [7:4] fifo count zero-extended, [31:8] 0.
- Reset (async, takes effect immediately):
  - txd=1; FIFO cleared; ackToggle=0; state=IDLE; baud and bit counters 0.
  - portInputWord=0x00000004.
- Handshake:
  - A request is pending when portOutputWord[8] != ackToggle.
  - If a request is pending and the FIFO is not full at a posedge: push portOutputWord[7:0] and set ackToggle<=portOutputWord[8]. The status word shows the new ack one cycle after the edge.
  - If the FIFO is full: no push and ackToggle is held. The request stays pending and is accepted at the first posedge with space.
  - Rewriting the data byte without flipping bit 8 is not a request.
  - After reset, a CPU-side bit 8 = 1 counts as a pending request. The system resets the CPU and this block together.
- FIFO:
  - Full and empty are evaluated on pre-edge state.
  - Push and pop on the same edge are both honoured.
  - Count is unchanged when both happen.
  - A pending request while full is rejected even if a pop happens on the same edge; it is accepted next cycle.
- Transmit FSM (UartTxState_t):
  - IDLE: txd=1. If FIFO is non-empty at a posedge: pop into a shift register, go to START, reload the baud counter.
  - START: txd=0 for CLOCKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first, CLOCKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLOCKS_PER_BIT cycles, then IDLE.
  - Every frame is exactly 10*CLOCKS_PER_BIT cycles, followed by exactly 1 IDLE cycle before the next start bit.
- Baud counter:
  - Width $clog2(CLOCKS_PER_BIT); counts CLOCKS_PER_BIT-1 down to 0.
  - Wraps by reload on each bit boundary.
- Bit counter: 3 bits, no wrap; the transition to STOP occurs at index 7.
- txd is driven from a register so there are no glitches; txd changes only at state or bit boundaries.
- portOutputWord is from the same clock domain; no synchroniser is needed.

Decomposition:
- Shared package JZJCoreFTypes gets:
  - enum UartTxState_t {IDLE, START, DATA, STOP};
  - status bit-position localparams: STATUS_ACK=0, STATUS_FULL=1, STATUS_EMPTY=2, STATUS_BUSY=3, STATUS_COUNT_LSB=4.
- One sub-module, port_uart_tx_fifo:
  - Synchronous FIFO, parameter DEPTH_LOG2, 8-bit data.
  - Ports: push, pop, dataIn, dataOut, full, empty, count.
  - Async reset to empty.
- Top level holds the handshake, FSM, counters and status register.

Test Plan (CLOCKS_PER_BIT=4, FIFO_DEPTH_LOG2=2):
- Reset asserted mid-idle -> portInputWord=0x00000004 and txd=1 immediately; both held while reset is high.
- portOutputWord=0x00000155 -> one cycle later ack=1. txd gives 4 clocks of 0, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 4 clocks of 1; busy=1 for 40 cycles. Final status 0x00000005.
- Six requests of 0x00000, 0x101, 0x002, 0x103, 0x004, 0x105, each issued once the prior ack is seen:
  - Byte 0 is popped at once.
  - Bytes 1-4 fill the FIFO: status full=1, count=4, i.e. 0x0000004A|ack.
  - The 6th request is not acked until byte 1 is popped; it is acked on the following cycle.
- portOutputWord changes 0x155 -> 0x1AA with bit 8 unchanged after ack -> no push, count and ack unchanged, no second frame.
- Two bytes queued -> stop bit of frame 1 ends, exactly 1 cycle of txd=1 in IDLE, then the start bit of frame 2.
- Reset pulsed during DATA bit 3 -> txd=1 at once, status 0x00000004, no residual bits or frames after reset is released.
